main_mem_responder: RTL and testbench

//   Word-addressed backing memory on the memory side of the data cache; answers the cache's refill/write-through requests.

---
 rtl/main_mem_responder_pkg.sv | 37 +++
 rtl/main_mem_responder_if.sv | 33 +++
 rtl/main_mem_responder_array.sv | 43 ++++
 rtl/main_mem_responder.sv | 170 +++++++++++++++++
 tb/tb_main_mem_responder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/main_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : main_mem_pkg
//  Purpose  : Shared types and constants for the main-memory responder:
//             FSM state enum, latency-counter width, request record and a
//             helper that computes the terminal latency-counter value.
//  Revision : 1.0 - initial release
// ============================================================================
package main_mem_pkg;

    localparam int LAT_CNT_W  = 8;
    localparam int REQ_ADDR_W = 32;
    // Widest data word the request record can hold; narrower words are
    // zero-extended into it.
    localparam int MAX_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                  wr;
        logic [REQ_ADDR_W-1:0] addr;
        logic [MAX_DATA_W-1:0] wdata;
    } req_t;

    // WAIT occupies LATENCY-1 cycles; the counter starts at 0 on accept, so
    // the last WAIT cycle is the one where the counter equals LATENCY-2.
    function automatic logic [LAT_CNT_W-1:0] lat_last(input int lat);
        return (lat > 1) ? LAT_CNT_W'(lat - 2) : '0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/main_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Interface : main_mem_responder_if
//  Purpose   : Request (valid/ready) and response (valid-only) channels
//              between the cache (master) and the backing memory (slave).
//  Signals   : req_valid/req_ready/req_wr/req_addr/req_wdata  - request
//              rsp_valid/rsp_rdata/rsp_last                   - response
//  Revision  : 1.0 - initial release
// ============================================================================
interface main_mem_responder_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_last;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_last
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_last
    );
endinterface

`default_nettype wire

// File: rtl/main_mem_responder_array.sv
`default_nettype none
// ============================================================================
//  Module   : main_mem_array
//  Purpose  : Single-port synchronous RAM, 1-cycle registered read,
//             write-first (a write returns the new data on o_rdata).
//             Contents are never reset.
//  Ports    : clk     - clock
//             i_we    - write enable
//             i_addr  - word address
//             i_wdata - write data
//             o_rdata - read data, valid the cycle after i_addr
//  Revision : 1.0 - initial release
// ============================================================================
module main_mem_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [DATA_W-1:0] i_wdata,
    output      logic [DATA_W-1:0] o_rdata
);

    localparam int c_depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [c_depth];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
            r_rdata       <= i_wdata;
        end else begin
            r_rdata       <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/main_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : main_mem_responder
//  Purpose  : Word-addressed backing memory answering cache refill and
//             write-through requests, one at a time, after a programmable
//             access latency.
//  Ports    : clk   - clock, rising edge
//             rst_n - asynchronous active-low reset
//             bus   - main_mem_responder_if.slave (request/response channels)
//  Config   : MAIN_MEM_BURST_EN - when defined, reads return LINE_WORDS
//             beats from the line-aligned base; otherwise single-beat reads.
//  Revision : 1.0 - initial release
// ============================================================================
module main_mem_responder
    import main_mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int LATENCY    = 4,
    parameter int LINE_WORDS = 4
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    main_mem_responder_if.slave     bus
);

    localparam logic [LAT_CNT_W-1:0] c_lat_last = lat_last(LATENCY);

    state_t                  r_state;
    state_t                  w_next;
    req_t                    r_req;
    logic [LAT_CNT_W-1:0]    r_lat_cnt;
    logic                    r_ready;

    logic                    w_accept;
    logic                    w_last_beat;
    logic                    w_cur_wr;
    logic [REQ_ADDR_W-1:0]   w_cur_addr;
    logic [DATA_W-1:0]       w_cur_wdata;
    logic                    w_we;
    logic [ADDR_W-1:0]       w_ram_addr;
    logic [DATA_W-1:0]       w_ram_rdata;

    // r_ready is only ever high in IDLE, so it alone qualifies acceptance.
    assign w_accept = bus.req_valid && r_ready;

    // With LATENCY=1 the RAM must be addressed in the accept cycle itself,
    // before the request is registered, so IDLE uses the live bus fields.
    assign w_cur_wr    = (r_state == IDLE) ? bus.req_wr    : r_req.wr;
    assign w_cur_addr  = (r_state == IDLE) ? bus.req_addr  : r_req.addr;
    assign w_cur_wdata = (r_state == IDLE) ? bus.req_wdata : r_req.wdata[DATA_W-1:0];

    // Commit a write on the edge entering RESP. rst_n gates it so a clock
    // edge during reset can never commit a dropped request.
    assign w_we = rst_n && w_cur_wr && (w_next == RESP) && (r_state != RESP);

`ifdef MAIN_MEM_BURST_EN
    localparam int c_off_w = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    logic [c_off_w-1:0] r_beat;
    logic [c_off_w-1:0] w_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat <= '0;
        end else if ((r_state == RESP) && (w_next == RESP)) begin
            r_beat <= r_beat + 1'b1;
        end else begin
            r_beat <= '0;
        end
    end

    // The RAM is addressed one beat ahead: offset 0 before RESP, then
    // beat+1 during RESP, so each registered read lands on its beat.
    assign w_off       = (r_state == RESP) ? (r_beat + 1'b1) : '0;
    assign w_ram_addr  = w_cur_wr ? w_cur_addr[ADDR_W-1:0]
                                  : {w_cur_addr[ADDR_W-1:c_off_w], w_off};
    assign w_last_beat = r_req.wr || (r_beat == c_off_w'(LINE_WORDS - 1));
`else
    assign w_ram_addr  = w_cur_addr[ADDR_W-1:0];
    assign w_last_beat = 1'b1;
`endif

    // Upper address bits alias away and unused record bits are sunk here.
    logic w_unused_bits;
    assign w_unused_bits = ^{r_req.wdata, w_cur_addr, 32'(LINE_WORDS)};

    main_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_cur_wdata),
        .o_rdata (w_ram_rdata)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_lat_cnt == c_lat_last) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                if (w_last_beat) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.rsp_valid = 1'b0;
        bus.rsp_last  = 1'b0;
        bus.rsp_rdata = '0;
        if (r_state == RESP) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_last  = w_last_beat;
            if (!r_req.wr) begin
                bus.rsp_rdata = w_ram_rdata;
            end
        end
    end

    assign bus.req_ready = r_ready;

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_cnt   <= '0;
            r_req       <= '0;
            r_ready     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lat_cnt   <= '0;
                r_req.wr    <= bus.req_wr;
                r_req.addr  <= bus.req_addr;
                r_req.wdata <= MAX_DATA_W'(bus.req_wdata);
            end else if (r_state == WAIT) begin
                r_lat_cnt   <= r_lat_cnt + 1'b1;
            end
            // Ready rises the cycle after the last beat and drops the
            // cycle after accept.
            r_ready <= (w_next == IDLE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_main_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_main_mem_responder
//  Purpose  : Scoreboard bench for main_mem_responder. The driver pushes the
//             expected beat(s) (data, last flag, cycle) when a request is
//             accepted; a monitor pops and compares on every response beat.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_main_mem_responder;

    localparam int LAT = 4;

    typedef struct {
        logic [31:0] d;
        logic        l;
        int          c;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    main_mem_responder_if #(.DATA_W(32)) bus ();

    main_mem_responder #(
        .DATA_W     (32),
        .ADDR_W     (10),
        .LATENCY    (LAT),
        .LINE_WORDS (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- Monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rsp_valid) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rsp: got data=%h last=%0b at cyc=%0d, required no response",
                             bus.rsp_rdata, bus.rsp_last, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (bus.rsp_rdata !== e.d || bus.rsp_last !== e.l || cyc != e.c) begin
                        failures++;
                        $display("FAIL rsp_beat: got data=%h last=%0b cyc=%0d, required data=%h last=%0b cyc=%0d",
                                 bus.rsp_rdata, bus.rsp_last, cyc, e.d, e.l, e.c);
                    end
                end
            end else begin
                checks++;
                if (bus.rsp_rdata !== 32'h0 || bus.rsp_last !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_rsp: got data=%h last=%0b, required 0/0", bus.rsp_rdata, bus.rsp_last);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Drive a request, hold it until accepted, push expectations.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_d, input int beats, output int acc);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got req_ready=0 after 200 cycles, required 1");
            bus.req_valid = 1'b0;
            acc = -1;
        end else begin
            // Accepted at the next edge (cyc+1); first beat LAT-1 cycles later.
            for (int k = 0; k < beats; k++) begin
                exp_t e;
                e.d = wr ? 32'h0 : exp_d + 32'(k);
                e.l = (k == beats - 1);
                e.c = cyc + LAT + k;
                q.push_back(e);
            end
            @(posedge clk);
            #1;
            acc = cyc;
            bus.req_valid = 1'b0;
        end
    endtask

    int a1, a2, dummy;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;

        // ---- 1: reset ----
        repeat (2) @(posedge clk);
        #2;
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("reset_rsp_last",  32'(bus.rsp_last),  32'h0);
        chk("reset_req_ready", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", 32'(bus.req_ready), 32'h1);

        // ---- 2: write/write/read/read ----
        issue(1'b1, 32'd0, 32'h1, 32'h0, 1, dummy);
        issue(1'b1, 32'd1, 32'h3, 32'h0, 1, dummy);
        issue(1'b0, 32'd1, 32'h0, 32'h3, 1, dummy);
        issue(1'b0, 32'd0, 32'h0, 32'h1, 1, dummy);

        // ---- 3: busy ----
        issue(1'b0, 32'd1, 32'h0, 32'h3, 1, a1);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 32'd0;
        @(negedge clk);
        chk("busy_ready_wait1", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        chk("busy_ready_wait2", 32'(bus.req_ready), 32'h0);
        issue(1'b0, 32'd0, 32'h0, 32'h1, 1, a2);
        chk("busy_accept_cycle", 32'(a2 - a1), 32'(LAT + 1));

        // ---- 4: address wrap ----
        issue(1'b1, 32'h400, 32'hA5, 32'h0, 1, dummy);
        issue(1'b0, 32'h000, 32'h0, 32'hA5, 1, dummy);

        // ---- 5: reset mid-operation ----
        issue(1'b1, 32'd2, 32'h22, 32'h0, 1, dummy);
        repeat (LAT + 2) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 32'd2;
        bus.req_wdata = 32'hFF;
        chk("midop_ready_before", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midop_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("midop_req_ready", 32'(bus.req_ready), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midop_ready_release", 32'(bus.req_ready), 32'h1);
        repeat (LAT + 2) @(negedge clk);
        issue(1'b0, 32'd2, 32'h0, 32'h22, 1, dummy);

        // ---- 6: line preload and read @6 ----
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 32'(4 + i), 32'(10 + i), 32'h0, 1, dummy);
        end
`ifdef MAIN_MEM_BURST_EN
        issue(1'b0, 32'd6, 32'h0, 32'd10, 4, dummy);
`else
        issue(1'b0, 32'd6, 32'h0, 32'd12, 1, dummy);
`endif

        // ---- drain ----
        for (int n = 0; n < 50 && q.size() != 0; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d outstanding beats, required 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running, required finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
